vx_core_req_bank_dispatch: RTL

- Request-side counterpart of the cache's per-bank core response merge.
- Takes the per-lane core request bus (NUM_REQS lanes, independent valid/ready per lane), selects a target bank from each lane's word address, and arbitrates lanes that collide on the same bank.
- Delivers one request per bank per cycle through a registered per-bank output stage carrying the lane id (tid), which the response path uses to route data back.
- Sits between the core request interface and the cache bank array.

---
 rtl/vx_core_req_bank_dispatch.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vx_core_req_bank_dispatch.sv
// Core request bank dispatch: routes per-lane core requests to cache banks.
// Lowest-index lane wins a contended bank; one registered request per bank.
module vx_core_req_bank_dispatch #(
    parameter int NUM_REQS       = 4,
    parameter int NUM_BANKS      = 4,
    parameter int WORD_SIZE      = 4,
    parameter int ADDR_WIDTH     = 30,
    parameter int CORE_TAG_WIDTH = 8,
    localparam int REQS_BITS       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int BANK_SEL_BITS   = $clog2(NUM_BANKS),
    localparam int BANK_ADDR_WIDTH = ADDR_WIDTH - BANK_SEL_BITS,
    localparam int DW              = 8 * WORD_SIZE
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQS-1:0]                   core_req_valid,
    input  logic [NUM_REQS-1:0]                   core_req_rw,
    input  logic [NUM_REQS*WORD_SIZE-1:0]         core_req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]        core_req_addr,
    input  logic [NUM_REQS*DW-1:0]                core_req_data,
    input  logic [NUM_REQS*CORE_TAG_WIDTH-1:0]    core_req_tag,
    output logic [NUM_REQS-1:0]                   core_req_ready,
    output logic [NUM_BANKS-1:0]                  per_bank_req_valid,
    output logic [NUM_BANKS-1:0]                  per_bank_req_rw,
    output logic [NUM_BANKS*WORD_SIZE-1:0]        per_bank_req_byteen,
    output logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0]  per_bank_req_addr,
    output logic [NUM_BANKS*DW-1:0]               per_bank_req_data,
    output logic [NUM_BANKS*CORE_TAG_WIDTH-1:0]   per_bank_req_tag,
    output logic [NUM_BANKS*REQS_BITS-1:0]        per_bank_req_tid,
    input  logic [NUM_BANKS-1:0]                  per_bank_req_ready,
    output logic [15:0]                           perf_bank_stalls
);

    localparam int BSW = (BANK_SEL_BITS > 0) ? BANK_SEL_BITS : 1;

    logic [BSW-1:0]             lane_bank  [NUM_REQS];
    logic [BANK_ADDR_WIDTH-1:0] lane_baddr [NUM_REQS];

    logic [NUM_BANKS-1:0] bank_load;
    logic [NUM_BANKS-1:0] bank_hit;
    logic [NUM_BANKS-1:0] bank_grant;
    logic [REQS_BITS-1:0] bank_win [NUM_BANKS];
    logic [NUM_REQS-1:0]  lane_rdy;
    logic                 any_stall;

    logic [NUM_BANKS-1:0]                 valid_q, valid_d;
    logic [NUM_BANKS-1:0]                 rw_q, rw_d;
    logic [NUM_BANKS*WORD_SIZE-1:0]       byteen_q, byteen_d;
    logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_BANKS*DW-1:0]              data_q, data_d;
    logic [NUM_BANKS*CORE_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [NUM_BANKS*REQS_BITS-1:0]       tid_q, tid_d;
    logic [15:0]                          stalls_q, stalls_d;

    // Split each lane's word address into bank select and bank-local address.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
        if (NUM_BANKS == 1) begin : g_one
            assign lane_bank[i]  = '0;
            assign lane_baddr[i] = core_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin : g_multi
            assign lane_bank[i]  = core_req_addr[i*ADDR_WIDTH +: BANK_SEL_BITS];
            assign lane_baddr[i] =
                core_req_addr[i*ADDR_WIDTH+BANK_SEL_BITS +: BANK_ADDR_WIDTH];
        end
    end

    // Per-bank fixed-priority arbitration; scanning downward leaves the lowest lane.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_load[b] = ~valid_q[b] | per_bank_req_ready[b];
            bank_hit[b]  = 1'b0;
            bank_win[b]  = '0;
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                if (core_req_valid[i] && (lane_bank[i] == BSW'(b))) begin
                    bank_hit[b] = 1'b1;
                    bank_win[b] = REQS_BITS'(i);
                end
            end
            bank_grant[b] = bank_hit[b] & bank_load[b];
        end
    end

    // A lane is accepted only if it is the winner of a bank that can load.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            lane_rdy[i] = core_req_valid[i]
                        && bank_grant[lane_bank[i]]
                        && (bank_win[lane_bank[i]] == REQS_BITS'(i));
        end
        core_req_ready = lane_rdy & {NUM_REQS{reset}};
        any_stall      = |(core_req_valid & ~lane_rdy);
    end

    // Output stage next state; payload only moves on a winning capture.
    always_comb begin
        valid_d  = valid_q;
        rw_d     = rw_q;
        byteen_d = byteen_q;
        addr_d   = addr_q;
        data_d   = data_q;
        tag_d    = tag_q;
        tid_d    = tid_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            valid_d[b] = bank_grant[b] | (valid_q[b] & ~per_bank_req_ready[b]);
            if (bank_grant[b]) begin
                rw_d[b] = core_req_rw[bank_win[b]];
                byteen_d[b*WORD_SIZE +: WORD_SIZE] =
                    core_req_byteen[bank_win[b]*WORD_SIZE +: WORD_SIZE];
                addr_d[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] =
                    lane_baddr[bank_win[b]];
                data_d[b*DW +: DW] = core_req_data[bank_win[b]*DW +: DW];
                tag_d[b*CORE_TAG_WIDTH +: CORE_TAG_WIDTH] =
                    core_req_tag[bank_win[b]*CORE_TAG_WIDTH +: CORE_TAG_WIDTH];
                tid_d[b*REQS_BITS +: REQS_BITS] = bank_win[b];
            end
        end
    end

    // Stall counter: one count per cycle with any waiting lane, saturating.
    always_comb begin
        stalls_d = stalls_q;
        if (any_stall && (stalls_q != 16'hFFFF)) begin
            stalls_d = stalls_q + 16'd1;
        end
    end

    // State registers; reset discards in-flight entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            rw_q     <= '0;
            byteen_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            tid_q    <= '0;
            stalls_q <= '0;
        end else begin
            valid_q  <= valid_d;
            rw_q     <= rw_d;
            byteen_q <= byteen_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            tid_q    <= tid_d;
            stalls_q <= stalls_d;
        end
    end

    assign per_bank_req_valid  = valid_q;
    assign per_bank_req_rw     = rw_q;
    assign per_bank_req_byteen = byteen_q;
    assign per_bank_req_addr   = addr_q;
    assign per_bank_req_data   = data_q;
    assign per_bank_req_tag    = tag_q;
    assign per_bank_req_tid    = tid_q;
    assign perf_bank_stalls    = stalls_q;

endmodule
